// File: rtl/column_loader.sv
// Write-side loader for one column's ram_ifm bank: streams words in at ascending addresses,
// then holds the bank as valid until the reader releases it.
module column_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  bank_valid,
  // "release" is a reserved word in SystemVerilog, hence the prefix
  input  logic                  bank_release,
  output logic [ADDR_WIDTH:0]   fill_count
);

  localparam int unsigned CntWidth = ADDR_WIDTH + 1;
  localparam logic [CntWidth-1:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e                  state_q, state_d;
  logic [CntWidth-1:0]     len_q, len_d;
  logic [CntWidth-1:0]     fill_q, fill_d;
  logic                    wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic [CntWidth-1:0]     fill_inc;
  logic                    xfer;

  assign in_ready   = (state_q == StLoad) & clk_en;
  assign xfer       = in_valid & in_ready;
  assign fill_inc   = fill_q + CntWidth'(1);
  assign busy       = (state_q == StLoad);
  assign bank_valid = (state_q == StFull);
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;
  assign fill_count = fill_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    fill_d    = fill_q;
    wr_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && (length != '0)) begin
          // Clamp so addresses never wrap inside one column
          len_d   = (length > Depth) ? Depth : length;
          fill_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (xfer) begin
          wr_req_d  = 1'b1;
          wr_addr_d = fill_q[ADDR_WIDTH-1:0];
          wr_data_d = in_data;
          fill_d    = fill_inc;
          if (fill_inc == len_q) begin
            state_d = StFull;
            done_d  = 1'b1;
          end
        end
      end
      StFull: begin
        if (bank_release) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      fill_q    <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_column_loader.sv
// Bench for column_loader: vector table for the basic/hold/release flow, directed corner
// sequences, and randomized traffic checked against a transaction-level model.
module tb_column_loader;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          start;
  logic [AW:0]   length;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          bank_valid;
  logic          bank_release;
  logic [AW:0]   fill_count;

  column_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .bank_valid(bank_valid),
    .bank_release(bank_release), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 loading, 2 bank held
  int m_mode, m_cnt, m_len, m_addr, m_data;
  bit m_wr, m_done;
  int n_wr, last_addr;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 0; length = 0; in_valid = 0; in_data = 0; clk_en = 1; bank_release = 0;
    m_mode = 0; m_cnt = 0; m_len = 0; m_wr = 0; m_done = 0; m_addr = 0; m_data = 0;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_req", int'(wr_req), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bank_valid", int'(bank_valid), 0);
    chk("rst_fill", int'(fill_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: drive inputs, check in_ready, clock, advance model, compare outputs.
  task automatic step(input bit st, input int len, input bit v, input int d, input bit ce,
                      input bit rel);
    start = st; length = (AW+1)'(len); in_valid = v; in_data = DW'(d);
    clk_en = ce; bank_release = rel;
    #1;
    chk("in_ready", int'(in_ready), (m_mode == 1 && ce) ? 1 : 0);
    @(posedge clk);
    if (ce) begin
      m_wr = 0; m_done = 0;
      if (m_mode == 0) begin
        if (st && len != 0) begin
          m_len = (len > DEPTH) ? DEPTH : len; m_cnt = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (v) begin
          m_wr = 1; m_addr = m_cnt; m_data = d % 256; m_cnt++;
          if (m_cnt == m_len) begin m_mode = 2; m_done = 1; end
        end
      end else if (rel) begin
        m_mode = 0;
      end
    end
    #1;
    if (ce && wr_req) begin n_wr++; last_addr = int'(wr_addr); end
    chk("wr_req", int'(wr_req), int'(m_wr));
    if (m_wr) begin
      chk("wr_addr", int'(wr_addr), m_addr);
      chk("wr_data", int'(wr_data), m_data);
    end
    chk("busy", int'(busy), (m_mode == 1) ? 1 : 0);
    chk("done", int'(done), int'(m_done));
    chk("bank_valid", int'(bank_valid), (m_mode == 2) ? 1 : 0);
    chk("fill_count", int'(fill_count), m_cnt);
  endtask

  typedef struct {
    int st, len, v, d, ce, rel;
    int e_rdy, e_wr, e_addr, e_data, e_busy, e_done, e_bv, e_fill;
  } vec_t;

  vec_t tbl[9];

  initial begin
    //          st len v d     ce rel  rdy wr addr data  busy done bv fill
    tbl[0] = '{1, 4,  0, 0,    1, 0,   1,  0, 0,   0,    1,   0,   0, 0};
    tbl[1] = '{0, 0,  1, 'h11, 1, 0,   1,  1, 0,   'h11, 1,   0,   0, 1};
    tbl[2] = '{0, 0,  1, 'h22, 1, 0,   1,  1, 1,   'h22, 1,   0,   0, 2};
    tbl[3] = '{0, 0,  1, 'h33, 1, 0,   1,  1, 2,   'h33, 1,   0,   0, 3};
    tbl[4] = '{0, 0,  1, 'h44, 1, 0,   0,  1, 3,   'h44, 0,   1,   1, 4};
    tbl[5] = '{0, 0,  0, 0,    1, 0,   0,  0, 0,   0,    0,   0,   1, 4};
    tbl[6] = '{1, 4,  0, 0,    1, 0,   0,  0, 0,   0,    0,   0,   1, 4};
    tbl[7] = '{1, 4,  0, 0,    1, 1,   0,  0, 0,   0,    0,   0,   0, 4};
    tbl[8] = '{1, 2,  0, 0,    1, 0,   1,  0, 0,   0,    1,   0,   0, 0};

    // Basic load, hold in FULL, release with coincident start, restart
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].st != 0, tbl[i].len, tbl[i].v != 0, tbl[i].d, tbl[i].ce != 0,
           tbl[i].rel != 0);
      chk($sformatf("vec%0d_in_ready", i), int'(in_ready), tbl[i].e_rdy);
      chk($sformatf("vec%0d_wr_req", i), int'(wr_req), tbl[i].e_wr);
      if (tbl[i].e_wr != 0) begin
        chk($sformatf("vec%0d_wr_addr", i), int'(wr_addr), tbl[i].e_addr);
        chk($sformatf("vec%0d_wr_data", i), int'(wr_data), tbl[i].e_data);
      end
      chk($sformatf("vec%0d_busy", i), int'(busy), tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i), int'(done), tbl[i].e_done);
      chk($sformatf("vec%0d_bank_valid", i), int'(bank_valid), tbl[i].e_bv);
      chk($sformatf("vec%0d_fill", i), int'(fill_count), tbl[i].e_fill);
    end

    // Stalls: clk_en low for two cycles right after a write, in_valid gaps
    do_reset();
    n_wr = 0;
    step(1, 3, 0, 0, 1, 0);
    step(0, 0, 1, 'hA1, 1, 0);
    step(0, 0, 1, 'hB2, 0, 0);
    step(0, 0, 1, 'hB2, 0, 0);
    step(0, 0, 0, 'hB2, 1, 0);
    step(0, 0, 1, 'hB2, 1, 0);
    step(0, 0, 1, 'hC3, 1, 0);
    step(0, 0, 1, 'hD4, 1, 0);
    chk("stall_nwrites", n_wr, 3);
    chk("stall_fill", int'(fill_count), 3);
    chk("stall_bank_valid", int'(bank_valid), 1);

    // Zero length is ignored, oversize length clamps to bank depth
    do_reset();
    step(1, 0, 0, 0, 1, 0);
    chk("zero_len_busy", int'(busy), 0);
    n_wr = 0;
    step(1, 100, 0, 0, 1, 0);
    for (int k = 0; k < 66; k++) step(0, 0, 1, k + 7, 1, 0);
    chk("clamp_nwrites", n_wr, 64);
    chk("clamp_last_addr", last_addr, 63);
    chk("clamp_fill", int'(fill_count), 64);
    chk("clamp_bank_valid", int'(bank_valid), 1);

    // Asynchronous reset mid-column, then a clean 5-word column
    step(0, 0, 0, 0, 1, 1);
    step(1, 5, 0, 0, 1, 0);
    step(0, 0, 1, 'h51, 1, 0);
    step(0, 0, 1, 'h52, 1, 0);
    #2;
    do_reset();
    n_wr = 0;
    step(1, 5, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 'h60 + k, 1, 0);
    chk("post_rst_nwrites", n_wr, 5);
    chk("post_rst_last_addr", last_addr, 4);
    chk("post_rst_bank_valid", int'(bank_valid), 1);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 80)), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 255)), $urandom_range(0, 4) != 0,
           $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
